alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one instance of the team's 32-bit `alu` between two requesters, e.g. the integer pipeline and the multi-cycle mul/div sequencer.
- Round-robin arbitration picks one request per issue slot.
- Operands go through the combinational ALU; result and flags are registered into a single response slot.
- The response is held until the owning requester accepts it.

Parameters:
- DATA_WIDTH, 32, operand/result width; must equal the ALU width.
- PTR_RESET, 0, round-robin pointer value after reset (0 = requester 0 has first priority).

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  reset, synchronous, active-low.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_A  input  DATA_WIDTH  operand A.
- req0_B  input  DATA_WIDTH  operand B.
- req0_ALUop  input  3  ALU opcode (AND/OR/ADD/SLTU/XOR/NOR/SUB/SLT encoding).
- req1_valid, req1_ready, req1_A, req1_B, req1_ALUop: same as the req0 ports, for requester 1.
- resp0_valid  output  1  response slot holds requester 0's result.
- resp0_ready  input  1  requester 0 takes the response.
- resp1_valid  output  1  response slot holds requester 1's result.
- resp1_ready  input  1  requester 1 takes the response.
- resp_Result  output  DATA_WIDTH  registered ALU Result.
- resp_Overflow  output  1  registered Overflow.
- resp_CarryOut  output  1  registered CarryOut.
- resp_Zero  output  1  registered Zero.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is sampled only on the clk rising edge while resetn=0.
  - Reset values: state=IDLE, ptr=PTR_RESET, owner=0, resp_Result=0, all flag regs=0, resp0_valid=resp1_valid=0, req0_ready=req1_ready=0.
- FSM, two states:
  - IDLE: response slot empty.
  - RESP: response slot full.
- Grant, combinational, in IDLE only:
  - Only one valid → that requester is granted.
  - Both valid → requester `ptr` is granted.
  - Neither valid → no grant.
  - reqN_ready = (state==IDLE) & grant==N. Both readies are 0 in RESP.
- Issue (IDLE, reqN_valid & reqN_ready):
  - Granted requester's A/B/ALUop are muxed into the ALU.
  - Result and flags are captured at the next edge; owner<=N, state<=RESP, ptr<=~N.
  - ptr changes only on an accepted issue.
- Response (RESP):
  - resp{owner}_valid=1; the other resp valid is 0.
  - resp_* are stable until the handshake completes.
  - When resp{owner}_ready=1: state<=IDLE, resp valid drops next cycle.
  - The ready of the non-owner requester is ignored.
- Latency and throughput:
  - Issue in cycle N → response valid in cycle N+1.
  - No issue in the cycle a response drains, so peak throughput is one operation per 2 cycles.
- Requester rules:
  - A requester must hold valid, A, B and ALUop stable while valid & !ready.
  - Dropping valid before ready is allowed; that request is simply not issued.
- resp_* data outputs keep their last value after drain; they are not cleared.
- Reset mid-operation (resetn=0 in RESP): response is discarded, state returns to IDLE, ptr=PTR_RESET, no ready asserted during reset.
- Undefined ALUop values cannot occur, since all 8 codes are defined. Result and flag semantics are exactly those of `alu`.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, two output ports are added: grant_cnt0 and grant_cnt1, each 32 bits.
  - Each counter increments by 1 in the cycle after an accepted issue for its requester.
  - Counters wrap from 0xFFFFFFFF to 0.
  - Both counters reset to 0.
  - Counters are not affected by response backpressure.
- When undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
1. Requester 0 ADD:
   - Stimulus: after reset, req0 valid with ADD A=0x7FFFFFFF B=0x00000001.
   - Expected: req0_ready=1 same cycle; next cycle resp0_valid=1, resp_Result=0x80000000, Overflow=1, CarryOut=0, Zero=0.
2. Requester 1 SUB:
   - Stimulus: req1 SUB A=3 B=5.
   - Expected: resp1_valid with resp_Result=0xFFFFFFFE, CarryOut=1, Overflow=0.
   - Follow-up: SLTU A=3 B=5 returns Result=1.
3. Round-robin fairness:
   - Stimulus: both requesters continuously valid from reset with resp ready tied high.
   - Expected: grant order 0,1,0,1; each response valid exactly 1 cycle after its issue; issues spaced 2 cycles apart.
4. Backpressure:
   - Stimulus: req0 AND A=0xF0F0F0F0 B=0xFF00FF00, resp0_ready held 0 for 5 cycles, req1 valid throughout.
   - Expected: resp0_valid stays 1, resp_Result stays 0xF000F000, req1_ready=0 throughout.
   - Then: req1 is granted in the IDLE cycle following resp0_ready=1.
5. Reset mid-operation:
   - Stimulus: resetn=0 for one cycle while in RESP.
   - Expected: next cycle resp0_valid=resp1_valid=0, resp_Result=0; with both requesters valid afterwards, requester 0 is granted first.
6. Stats counters (ALU_ARB_STATS_EN defined):
   - Stimulus: 3 issues to requester 0 and 2 to requester 1.
   - Expected: grant_cnt0=3, grant_cnt1=2.
   - Wrap check: preload-by-force grant_cnt0=0xFFFFFFFF, one issue → grant_cnt0=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational 32-bit ALU between two requesters, with a
// single registered response slot. Define ALU_ARB_STATS_EN to add per-requester grant counters.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter bit PTR_RESET  = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_A,
    input  logic [DATA_WIDTH-1:0] req0_B,
    input  logic [2:0]            req0_ALUop,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_A,
    input  logic [DATA_WIDTH-1:0] req1_B,
    input  logic [2:0]            req1_ALUop,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp_Result,
    output logic                  resp_Overflow,
    output logic                  resp_CarryOut,
    output logic                  resp_Zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]           grant_cnt0,
    output logic [31:0]           grant_cnt1
`endif
);
    localparam int MSB = DATA_WIDTH - 1;

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t                r_state;
    logic                  r_ptr;
    logic                  r_owner;
    logic                  r_resp0_valid;
    logic                  r_resp1_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_ovf;
    logic                  r_cout;
    logic                  r_zero;

    logic                  w_gnt_any;
    logic                  w_gnt_id;
    logic                  w_resp_take;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [2:0]            w_op;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_diff;
    logic                  w_carry_add;
    logic                  w_nborrow;
    logic                  w_ovf_add;
    logic                  w_ovf_sub;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_ovf;
    logic                  w_cout;

    // Readies are gated by resetn so nothing is offered while reset is held.
    assign w_gnt_id   = (req0_valid & req1_valid) ? r_ptr : req1_valid;
    assign w_gnt_any  = resetn & (r_state == IDLE) & (req0_valid | req1_valid);
    assign req0_ready = w_gnt_any & ~w_gnt_id;
    assign req1_ready = w_gnt_any &  w_gnt_id;

    assign w_a  = w_gnt_id ? req1_A     : req0_A;
    assign w_b  = w_gnt_id ? req1_B     : req0_B;
    assign w_op = w_gnt_id ? req1_ALUop : req0_ALUop;

    assign {w_carry_add, w_sum} = {1'b0, w_a} + {1'b0, w_b};
    assign {w_nborrow, w_diff}  = {1'b0, w_a} + {1'b0, ~w_b} + {{DATA_WIDTH{1'b0}}, 1'b1};
    assign w_ovf_add = (w_a[MSB] == w_b[MSB]) & (w_sum[MSB]  != w_a[MSB]);
    assign w_ovf_sub = (w_a[MSB] != w_b[MSB]) & (w_diff[MSB] != w_a[MSB]);

    // CarryOut on SUB reports a borrow (A < B unsigned); flags are 0 for non-arithmetic ops.
    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        w_cout   = 1'b0;
        case (w_op)
            3'b000: w_result = w_a & w_b;
            3'b001: w_result = w_a | w_b;
            3'b010: begin
                w_result = w_sum;
                w_ovf    = w_ovf_add;
                w_cout   = w_carry_add;
            end
            3'b011: w_result = {{(DATA_WIDTH-1){1'b0}}, ~w_nborrow};
            3'b100: w_result = w_a ^ w_b;
            3'b101: w_result = ~(w_a | w_b);
            3'b110: begin
                w_result = w_diff;
                w_ovf    = w_ovf_sub;
                w_cout   = ~w_nborrow;
            end
            default: w_result = {{(DATA_WIDTH-1){1'b0}}, w_diff[MSB] ^ w_ovf_sub};
        endcase
    end

    assign w_resp_take = r_owner ? resp1_ready : resp0_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_ptr         <= PTR_RESET;
            r_owner       <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_result      <= '0;
            r_ovf         <= 1'b0;
            r_cout        <= 1'b0;
            r_zero        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        r_state       <= RESP;
                        r_owner       <= w_gnt_id;
                        r_ptr         <= ~w_gnt_id;
                        r_resp0_valid <= ~w_gnt_id;
                        r_resp1_valid <= w_gnt_id;
                        r_result      <= w_result;
                        r_ovf         <= w_ovf;
                        r_cout        <= w_cout;
                        r_zero        <= (w_result == '0);
                    end
                end
                default: begin
                    if (w_resp_take) begin
                        r_state       <= IDLE;
                        r_resp0_valid <= 1'b0;
                        r_resp1_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign resp0_valid   = r_resp0_valid;
    assign resp1_valid   = r_resp1_valid;
    assign resp_Result   = r_result;
    assign resp_Overflow = r_ovf;
    assign resp_CarryOut = r_cout;
    assign resp_Zero     = r_zero;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] r_cnt0;
    logic [31:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_gnt_any) begin
            if (w_gnt_id) r_cnt1 <= r_cnt1 + 32'd1;
            else          r_cnt0 <= r_cnt0 + 32'd1;
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif
endmodule
